s_box_sequencer: RTL and testbench

Controller that drives the eight DES S-box lookup units (S1..S8) for one round of the f-function. It accepts a 48-bit expanded-and-key-mixed word and fans the 6-bit slices out to the S-box inputs. It sequences the per-box select lines, either one box per cycle or all at once, and checks each box's finish flag before capturing its 4-bit result. It then presents the assembled 32-bit substitution result to the P-permutation stage with a one-cycle done pulse.

---
 rtl/s_box_sequencer.sv | 122 ++++++++++++
 tb/tb_s_box_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/s_box_sequencer.sv
// Sequencer for the eight DES S-box units of one f-function round: latches the
// 48-bit word, walks or broadcasts the box selects, gathers the 4-bit results.
module s_box_sequencer #(
  parameter int PARALLEL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [48:1] data_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [32:1] data_out,
  output logic [48:1] sbox_in,
  output logic [8:1]  sbox_sel,
  input  logic [32:1] sbox_out,
  input  logic [8:1]  sbox_fin
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [32:1] res_q, res_d;
  logic [32:1] dout_d;
  logic [8:1]  sel_d;
  logic        done_d, err_d, latch;
  logic        cap_ok;

  // idx names the box captured this cycle; its result appears one cycle
  // after its select, so the select issued alongside it is for box idx+2.
  assign cap_ok = (PARALLEL != 0) ? (&sbox_fin) : sbox_fin[idx_q];
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        if (!cap_ok)                               state_d = IDLE;
        else if ((PARALLEL != 0) || idx_q == 4'd8) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d  = '0;
    done_d = 1'b0;
    err_d  = 1'b0;
    latch  = 1'b0;
    idx_d  = idx_q;
    res_d  = res_q;
    dout_d = data_out;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch = 1'b1;
          idx_d = 4'd1;
          res_d = '0;
          sel_d = (PARALLEL != 0) ? 8'hFF : 8'h01;
        end
      end
      ISSUE: begin
        if (PARALLEL == 0) sel_d = 8'(1) << idx_q;
      end
      CAPTURE: begin
        if (!cap_ok) begin
          err_d = 1'b1;
          res_d = '0;
          idx_d = 4'd1;
        end else if (PARALLEL != 0) begin
          res_d  = sbox_out;
          dout_d = sbox_out;
          done_d = 1'b1;
        end else begin
          for (int unsigned n = 1; n <= 8; n++) begin
            if (idx_q == 4'(n)) res_d[36-4*n -: 4] = sbox_out[36-4*n -: 4];
          end
          if (idx_q == 4'd8) begin
            dout_d = res_d;
            done_d = 1'b1;
            idx_d  = 4'd1;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q <= 4'd6) sel_d = 8'(1) << (idx_q + 4'd1);
          end
        end
      end
      DONE:    idx_d = 4'd1;
      default: idx_d = 4'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 4'd1;
      res_q    <= '0;
      sbox_sel <= '0;
      sbox_in  <= '0;
      data_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      res_q    <= res_d;
      sbox_sel <= sel_d;
      done     <= done_d;
      err      <= err_d;
      data_out <= dout_d;
      if (latch) sbox_in <= data_in;
    end
  end

endmodule

// File: tb/tb_s_box_sequencer.sv
// Bench for s_box_sequencer: serial and parallel instances, DES S-box unit
// models with one-cycle latency, and a table-driven reference of the round.
module tb_s_box_sequencer;

  logic clk, rst_n;

  logic        s_start, s_busy, s_done, s_err;
  logic [48:1] s_din, s_sbin;
  logic [32:1] s_dout, s_out;
  logic [8:1]  s_sel, s_fin;

  logic        p_start, p_busy, p_done, p_err;
  logic [48:1] p_din, p_sbin;
  logic [32:1] p_dout, p_out;
  logic [8:1]  p_sel, p_fin;

  int checks = 0;
  int errors = 0;
  int drop_s = 0;
  int drop_p = 0;
  logic [31:0] exp_dout_s = '0;
  logic [31:0] exp_dout_p = '0;

  s_box_sequencer #(.PARALLEL(0)) u_ser (
    .clk(clk), .rst_n(rst_n), .start(s_start), .data_in(s_din), .busy(s_busy),
    .done(s_done), .err(s_err), .data_out(s_dout), .sbox_in(s_sbin),
    .sbox_sel(s_sel), .sbox_out(s_out), .sbox_fin(s_fin));

  s_box_sequencer #(.PARALLEL(1)) u_par (
    .clk(clk), .rst_n(rst_n), .start(p_start), .data_in(p_din), .busy(p_busy),
    .done(p_done), .err(p_err), .data_out(p_dout), .sbox_in(p_sbin),
    .sbox_sel(p_sel), .sbox_out(p_out), .sbox_fin(p_fin));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int sb [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  // Outer bits pick the row, inner four the column.
  function automatic logic [3:0] sbox_lut(input int box, input logic [5:0] b);
    return 4'(sb[box-1][{b[5], b[0]}][b[4:1]]);
  endfunction

  function automatic logic [31:0] ref_sub(input logic [48:1] d);
    logic [32:1] r;
    for (int n = 1; n <= 8; n++) r[36-4*n -: 4] = sbox_lut(n, d[54-6*n -: 6]);
    return r;
  endfunction

  // Unselected or suppressed boxes report no finish and garbage data.
  function automatic logic [40:1] unit_eval(input logic [8:1] sel, input logic [48:1] sbin,
                                            input int drop);
    logic [8:1]  f;
    logic [32:1] o;
    for (int n = 1; n <= 8; n++) begin
      if (sel[n] && drop != n) begin
        f[n] = 1'b1;
        o[36-4*n -: 4] = sbox_lut(n, sbin[54-6*n -: 6]);
      end else begin
        f[n] = 1'b0;
        o[36-4*n -: 4] = 4'($urandom);
      end
    end
    return {f, o};
  endfunction

  always @(posedge clk) begin
    {s_fin, s_out} <= unit_eval(s_sel, s_sbin, drop_s);
    {p_fin, p_out} <= unit_eval(p_sel, p_sbin, drop_p);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_round(input bit par, input logic [48:1] d, input int drop,
                           input int restart_at);
    int L, extra_done, extra_busy;
    logic [7:0] esel;
    logic [31:0] exp_res;
    exp_res = ref_sub(d);
    L = (drop == 0) ? (par ? 3 : 10) : (par ? 3 : drop + 2);
    if (par) drop_p = drop; else drop_s = drop;
    @(negedge clk);
    if (par) begin p_din = d; p_start = 1'b1; end
    else     begin s_din = d; s_start = 1'b1; end
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      p_start = 1'b0;
      s_start = (!par && k == restart_at);
      if (s_start) s_din = {16'($urandom), $urandom};
      if (k >= L)      esel = 8'h00;
      else if (par)    esel = (k == 1) ? 8'hFF : 8'h00;
      else             esel = (k <= 8) ? (8'h01 << (k - 1)) : 8'h00;
      check("sel",  par ? p_sel  : s_sel,  esel);
      check("busy", par ? p_busy : s_busy, (drop == 0) ? (k <= L) : (k < L));
      check("done", par ? p_done : s_done, (drop == 0) && (k == L));
      check("err",  par ? p_err  : s_err,  (drop != 0) && (k == L));
      if (k == 1 || k == L - 1) check("sbox_in", par ? p_sbin : s_sbin, d);
    end
    s_start = 1'b0;
    if (drop == 0) begin
      if (par) exp_dout_p = exp_res; else exp_dout_s = exp_res;
    end
    check("data_out", par ? p_dout : s_dout, par ? exp_dout_p : exp_dout_s);
    drop_s = 0;
    drop_p = 0;
    if (restart_at > 0) begin
      extra_done = 0;
      extra_busy = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (s_done) extra_done++;
        if (s_busy) extra_busy++;
      end
      check("restart_done", extra_done, 0);
      check("restart_busy", extra_busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_start = 1'b0; p_start = 1'b0;
    s_din = '0; p_din = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {s_busy, p_busy}, 2'b00);
    check("rst_pulses", {s_done, s_err, p_done, p_err}, 4'h0);
    check("rst_sel", {s_sel, p_sel}, 16'h0);
    check("rst_sbin", {s_sbin, p_sbin}, 96'h0);
    check("rst_dout", {s_dout, p_dout}, 64'h0);
    rst_n = 1'b1;

    run_round(0, 48'h0, 0, 0);
    check("ser_zero", s_dout, 32'hEFA72C4D);
    run_round(0, 48'hFFFF_FFFF_FFFF, 0, 0);
    check("ser_ones", s_dout, 32'hD9CE3DCB);
    run_round(1, 48'h0, 0, 0);
    check("par_zero", p_dout, 32'hEFA72C4D);
    run_round(0, {16'($urandom), $urandom}, 5, 0);
    check("abort_keep", s_dout, 32'hD9CE3DCB);
    run_round(0, {16'($urandom), $urandom}, 0, 3);

    // Reset four cycles into a round.
    @(negedge clk);
    s_din = {16'($urandom), $urandom};
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", s_busy, 1'b0);
    check("mid_rst_pulses", {s_done, s_err}, 2'b00);
    check("mid_rst_sel", s_sel, 8'h0);
    check("mid_rst_sbin", s_sbin, 48'h0);
    check("mid_rst_dout", {s_dout, p_dout}, 64'h0);
    exp_dout_s = '0;
    exp_dout_p = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_round(0, 48'h0, 0, 0);
    check("post_rst", s_dout, 32'hEFA72C4D);

    for (int i = 0; i < 10; i++) begin
      run_round(1'($urandom), {16'($urandom), $urandom},
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
